pipe_skid_buf: RTL and testbench



---
 rtl/pipe_skid_buf.sv | 131 +++++++++++++
 tb/tb_pipe_skid_buf.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buf.sv
// Two-entry register slice (output register + skid register) with valid/ready on both sides, flush and bubble insertion.
// Optional stall counter enabled by defining PIPE_SKID_BUF_STALL_CNT_EN.
module pipe_skid_buf #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  input  logic              flush
);

  // State encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [DATA_W-1:0] skidData_q, skidData_d;
  logic              inFire;
  logic              outFire;

  assign out_valid = state_q[1];
  assign in_ready  = ~state_q[0];
  assign out_data  = outData_q;

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      outData_q  <= NOP_VALUE;
      skidData_q <= NOP_VALUE;
    end else begin
      state_q    <= state_d;
      outData_q  <= outData_d;
      skidData_q <= skidData_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    outData_d  = outData_q;
    skidData_d = skidData_q;
    if (flush) begin
      // Flush squashes everything, including handshakes in the same cycle.
      state_d    = EMPTY;
      outData_d  = NOP_VALUE;
      skidData_d = NOP_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (inFire) begin
            state_d   = ONE;
            outData_d = in_data;
          end
        end
        ONE: begin
          if (outFire && inFire) begin
            outData_d = in_data;
          end else if (outFire) begin
            state_d   = EMPTY;
            outData_d = NOP_VALUE;
          end else if (inFire) begin
            state_d    = FULL;
            skidData_d = in_data;
          end
        end
        FULL: begin
          if (outFire) begin
            state_d    = ONE;
            outData_d  = skidData_q;
            skidData_d = NOP_VALUE;
          end
        end
        default: begin
          state_d    = EMPTY;
          outData_d  = NOP_VALUE;
          skidData_d = NOP_VALUE;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_BUF_STALL_CNT_EN
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  // Saturating count of cycles the next stage refused a valid word; only reset clears it.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (out_valid && !out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
  end
`endif

  // Structural properties: the unused encoding never appears and a stalled word is stable.
  a_no_illegal_state : assert property (
    @(posedge clk) disable iff (rst) state_q != 2'b01);

  a_hold_when_stalled : assert property (
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed-vector bench for pipe_skid_buf with NOP_VALUE=32'hDEAD_BEEF and CNT_W=4.
// Exercises the stall counter only when PIPE_SKID_BUF_STALL_CNT_EN is defined.
module tb_pipe_skid_buf;

  localparam int unsigned       DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP    = 32'hDEAD_BEEF;
  localparam int unsigned       CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              inValid;
  logic [DATA_W-1:0] inData;
  logic              inReady;
  logic              outValid;
  logic [DATA_W-1:0] outData;
  logic              outReady;
  logic              flush;
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
  logic [CNT_W-1:0]  stallCnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_skid_buf #(
    .DATA_W   (DATA_W),
    .NOP_VALUE(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_data  (inData),
    .in_ready (inReady),
    .out_valid(outValid),
    .out_data (outData),
    .out_ready(outReady),
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    .stall_cnt(stallCnt),
`endif
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
    inValid  = v;
    inData   = d;
    outReady = r;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkPort(input string tag, input logic v, input logic [31:0] d, input logic rdy);
    checkOutput({tag, ".valid"}, {31'd0, outValid}, {31'd0, v});
    checkOutput({tag, ".data"}, outData, d);
    checkOutput({tag, ".ready"}, {31'd0, inReady}, {31'd0, rdy});
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; inData = '0; outReady = 1'b0; flush = 1'b0;
    #12;
    checkPort("reset", 1'b0, NOP, 1'b1);
    rst = 1'b0;
    #1;

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
      checkPort($sformatf("stream%0d", i), 1'b1, 32'(i), 1'b1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkPort("drain", 1'b0, NOP, 1'b1);

    // Backpressure: A in output, B in skid, C waits upstream.
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
    checkPort("bpA", 1'b1, 32'hA, 1'b1);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
    checkPort("bpB", 1'b1, 32'hA, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
    checkPort("bpHold", 1'b1, 32'hA, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
    checkPort("bpOutB", 1'b1, 32'hB, 1'b1);
    applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
    checkPort("bpOutC", 1'b1, 32'hC, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkPort("bpEmpty", 1'b0, NOP, 1'b1);

    // Flush while FULL with a word offered.
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
    checkPort("flFull", 1'b1, 32'hA, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1);
    checkPort("flush", 1'b0, NOP, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkPort("flAfter", 1'b0, NOP, 1'b1);

    // Asynchronous reset between edges while holding a word.
    applyStimulus(1'b1, 32'h5A, 1'b0, 1'b0);
    checkPort("arOne", 1'b1, 32'h5A, 1'b1);
    inValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkPort("arAsync", 1'b0, NOP, 1'b1);
`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    checkOutput("arCnt", {28'd0, stallCnt}, 32'd0);
`endif
    rst = 1'b0;
    applyStimulus(1'b1, 32'hD, 1'b1, 1'b0);
    checkPort("arNext", 1'b1, 32'hD, 1'b1);

`ifdef PIPE_SKID_BUF_STALL_CNT_EN
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      if (k == 14) checkOutput("cnt14", {28'd0, stallCnt}, 32'd14);
    end
    checkOutput("cntSat", {28'd0, stallCnt}, 32'd15);
    checkPort("cntHold", 1'b1, 32'hD, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("cntFlush", {28'd0, stallCnt}, 32'd15);
    #2 rst = 1'b1;
    #1;
    checkOutput("cntRst", {28'd0, stallCnt}, 32'd0);
    rst = 1'b0;
`else
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkPort("holdD", 1'b1, 32'hD, 1'b1);
`endif

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkPort("final", 1'b0, NOP, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
